pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the PA-RISC style PC front/back queue and sequences it every cycle: sequential advance, delayed-branch redirect from the branch target generator, stall hold, and flush redirect.
- Produces the fetch address, delay-slot nullify, and the link write for BL.
- Sits between the fetch stage (drives instruction memory address) and decode/branch evaluation (consumes taken/target/nullify requests).

Parameters:
- PC_W, 8, width of PC front/back and all address ports
- RESET_PC, 0, value loaded into PC front on reset; PC back resets to RESET_PC+INC
- INC, 4, sequential increment in bytes

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold the PC queue this cycle (hazard from decode)
- br_valid  input  1  branch instruction resolved this cycle
- br_taken  input  1  condition evaluated true (qualified by br_valid)
- br_target  input  PC_W  branch target (front+8+4*offset, computed upstream)
- br_link  input  1  branch is BL, write return address
- br_nullify  input  1  n-bit of branch: nullify delay slot
- flush  input  1  redirect request (trap/restart)
- flush_pc  input  PC_W  redirect address
- pc_front  output  PC_W  fetch address of instruction entering pipe
- pc_back  output  PC_W  next address in queue
- fetch_valid  output  1  pc_front holds a real fetch this cycle
- slot_nullify  output  1  instruction at pc_front must be squashed
- link_we  output  1  one-cycle write strobe for GR[t]
- link_addr  output  PC_W  return address (pc_front+8 at branch resolution)
- state  output  2  FSM state for debug

Behaviour:
- Reset (async, any time incl. mid-branch): pc_front=RESET_PC, pc_back=RESET_PC+INC, fetch_valid=0, slot_nullify=0, link_we=0, link_addr=0, state=BOOT. Pending branch/nullify discarded.
- States: BOOT=0, RUN=1, STALL=2, NULL=3.
- BOOT: one cycle after reset release with fetch_valid=0, queue unchanged; next RUN (flush still honoured).
- Priority each edge: flush > stall > branch > sequential.
- flush=1 (any state): pc_front<=flush_pc, pc_back<=flush_pc+INC, slot_nullify<=0, link_we<=0; state<=RUN. Branch in the same cycle ignored.
- stall=1 (no flush): pc_front/pc_back hold, link_we<=0, state<=STALL, fetch_valid=0 while in STALL. Branch inputs ignored; decode holds br_* stable until stall drops. A pending slot_nullify is held and resumes on exit.
- RUN/NULL, no stall: pc_front<=pc_back. If br_valid&br_taken: pc_back<=br_target, else pc_back<=pc_back+INC.
- Nullify: br_valid&br_nullify&br_taken -> state<=NULL, slot_nullify=1 for the delay-slot instruction (exactly one issued instruction), then RUN. A branch resolved while in NULL is itself squashed: br_* ignored, sequential advance.
- Link: br_valid&br_link&br_taken (not squashed, not stalled) -> link_we=1 next cycle for one cycle, link_addr=pc_front+8 at resolution. link_addr holds its last value otherwise.
- Not-taken branch: sequential advance; no nullify, no link.
- Back-to-back taken branches (branch in delay slot, not nullified): second target enters pc_back, first target moves to pc_front. This is the architectural behaviour.
- Arithmetic: all additions modulo 2^PC_W; 0xFC+4 wraps to 0x00 silently.
- fetch_valid=1 in RUN and NULL.
- Outputs are registered; no combinational path from inputs to pc_front/pc_back.

Test Plan:
- Reset then 4 free cycles -> BOOT 1 cycle; pc_front 0,4,8,12; pc_back leads by 4; fetch_valid=0 only in BOOT.
- At pc_front=0x10, br_valid=1, br_taken=1, br_target=0x40, br_link=1 -> next pc_front=0x14 (delay slot), then 0x40; link_we pulses 1 cycle with link_addr=0x18.
- Same branch with br_nullify=1 -> pc_front=0x14 with slot_nullify=1, state=NULL; next 0x40 with slot_nullify=0. A branch asserted during the NULL cycle is ignored.
- stall for 3 cycles with br_valid held -> pc_front/pc_back frozen, fetch_valid=0, state=STALL; branch takes effect on the first unstalled edge. Assert flush=1, flush_pc=0x80 alongside stall -> pc_front=0x80, pc_back=0x84.
- pc_front=0xF8 sequential -> 0xFC, 0x00, 0x04 (wrap); taken branch with br_target=0x00 at 0xFC handled identically.
- Assert reset while in NULL with link pending -> all outputs at reset values immediately; no link_we after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// PA-RISC style PC front/back queue sequencer: sequential advance, delayed-branch
// redirect, stall hold, flush redirect, delay-slot nullify and BL link write.
module pc_sequencer #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int INC      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            br_link,
    input  logic            br_nullify,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic [PC_W-1:0] pc_front,
    output logic [PC_W-1:0] pc_back,
    output logic            fetch_valid,
    output logic            slot_nullify,
    output logic            link_we,
    output logic [PC_W-1:0] link_addr,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_NULL  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] INC_V      = PC_W'(INC);
    localparam logic [PC_W-1:0] RST_FRONT  = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] RST_BACK   = PC_W'(RESET_PC + INC);
    localparam logic [PC_W-1:0] LINK_OFF   = PC_W'(8);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_front_q, pc_front_d;
    logic [PC_W-1:0] pc_back_q, pc_back_d;
    logic            slot_nullify_q, slot_nullify_d;
    logic            link_we_q, link_we_d;
    logic [PC_W-1:0] link_addr_q, link_addr_d;
    logic            br_take;

    assign br_take = br_valid && br_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_BOOT;
            pc_front_q     <= RST_FRONT;
            pc_back_q      <= RST_BACK;
            slot_nullify_q <= 1'b0;
            link_we_q      <= 1'b0;
            link_addr_q    <= '0;
        end else begin
            state_q        <= state_d;
            pc_front_q     <= pc_front_d;
            pc_back_q      <= pc_back_d;
            slot_nullify_q <= slot_nullify_d;
            link_we_q      <= link_we_d;
            link_addr_q    <= link_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_RUN;
        end else if (state_q == S_BOOT) begin
            state_d = S_RUN;
        end else if (stall) begin
            state_d = S_STALL;
        end else if (state_q == S_STALL && slot_nullify_q) begin
            state_d = S_NULL;
        end else if (state_q == S_NULL) begin
            state_d = S_RUN;
        end else begin
            state_d = (br_take && br_nullify) ? S_NULL : S_RUN;
        end
    end

    always_comb begin
        pc_front_d     = pc_front_q;
        pc_back_d      = pc_back_q;
        slot_nullify_d = slot_nullify_q;
        link_we_d      = 1'b0;
        link_addr_d    = link_addr_q;
        if (flush) begin
            pc_front_d     = flush_pc;
            pc_back_d      = flush_pc + INC_V;
            slot_nullify_d = 1'b0;
        end else if (state_q == S_BOOT || stall) begin
            pc_front_d = pc_front_q;
        end else if (state_q == S_STALL && slot_nullify_q) begin
            // Held delay slot is re-presented, still squashed, once the stall lifts.
            pc_front_d = pc_front_q;
        end else if (state_q == S_NULL) begin
            // Branch resolving in a squashed slot is itself squashed.
            pc_front_d     = pc_back_q;
            pc_back_d      = pc_back_q + INC_V;
            slot_nullify_d = 1'b0;
        end else begin
            pc_front_d     = pc_back_q;
            pc_back_d      = br_take ? br_target : pc_back_q + INC_V;
            slot_nullify_d = br_take && br_nullify;
            link_we_d      = br_take && br_link;
            if (br_take && br_link) begin
                link_addr_d = pc_front_q + LINK_OFF;
            end
        end
    end

    always_comb begin
        fetch_valid = (state_q == S_RUN) || (state_q == S_NULL);
    end

    assign pc_front     = pc_front_q;
    assign pc_back      = pc_back_q;
    assign slot_nullify = slot_nullify_q;
    assign link_we      = link_we_q;
    assign link_addr    = link_addr_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, branch/link, nullify, stall, flush, wrap, async reset.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall, br_valid, br_taken, br_link, br_nullify, flush;
    logic [7:0] br_target, flush_pc;
    logic [7:0] pc_front, pc_back, link_addr;
    logic       fetch_valid, slot_nullify, link_we;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(.PC_W(8), .RESET_PC(0), .INC(4)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .br_link(br_link), .br_nullify(br_nullify),
        .flush(flush), .flush_pc(flush_pc),
        .pc_front(pc_front), .pc_back(pc_back), .fetch_valid(fetch_valid),
        .slot_nullify(slot_nullify), .link_we(link_we), .link_addr(link_addr),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string tag, input logic [7:0] f, input logic [7:0] b,
                         input logic [1:0] st, input logic fv);
        check({tag, ".front"}, pc_front, f);
        check({tag, ".back"}, pc_back, b);
        check({tag, ".state"}, state, st);
        check({tag, ".fv"}, fetch_valid, fv);
    endtask

    task automatic clr_br();
        br_valid = 0; br_taken = 0; br_link = 0; br_nullify = 0; br_target = 8'h00;
    endtask

    task automatic do_flush(input logic [7:0] pc);
        flush = 1; flush_pc = pc;
        step();
        flush = 0;
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; flush_pc = 8'h00;
        clr_br();
        #2;
        check("rst.front", pc_front, 8'h00);
        check("rst.back", pc_back, 8'h04);
        check("rst.fv", fetch_valid, 1'b0);
        check("rst.state", state, 2'd0);
        step(); step();
        reset = 0;
        chk_q("boot", 8'h00, 8'h04, 2'd0, 1'b0);
        step(); chk_q("seq0", 8'h00, 8'h04, 2'd1, 1'b1);
        step(); chk_q("seq1", 8'h04, 8'h08, 2'd1, 1'b1);
        step(); chk_q("seq2", 8'h08, 8'h0C, 2'd1, 1'b1);
        step(); chk_q("seq3", 8'h0C, 8'h10, 2'd1, 1'b1);
        step(); chk_q("seq4", 8'h10, 8'h14, 2'd1, 1'b1);

        // Taken BL at 0x10
        br_valid = 1; br_taken = 1; br_target = 8'h40; br_link = 1;
        step(); clr_br();
        chk_q("bl.slot", 8'h14, 8'h40, 2'd1, 1'b1);
        check("bl.lwe", link_we, 1'b1);
        check("bl.laddr", link_addr, 8'h18);
        check("bl.sn", slot_nullify, 1'b0);
        step();
        chk_q("bl.tgt", 8'h40, 8'h44, 2'd1, 1'b1);
        check("bl.lwe_off", link_we, 1'b0);
        check("bl.laddr_hold", link_addr, 8'h18);

        // Nullifying branch; branch during NULL is ignored
        do_flush(8'h10);
        chk_q("fl10", 8'h10, 8'h14, 2'd1, 1'b1);
        br_valid = 1; br_taken = 1; br_target = 8'h40; br_nullify = 1;
        step();
        chk_q("nul.slot", 8'h14, 8'h40, 2'd3, 1'b1);
        check("nul.sn", slot_nullify, 1'b1);
        br_target = 8'h60; br_link = 1; br_nullify = 0;
        step(); clr_br();
        chk_q("nul.tgt", 8'h40, 8'h44, 2'd1, 1'b1);
        check("nul.sn_off", slot_nullify, 1'b0);
        check("nul.lwe", link_we, 1'b0);
        check("nul.laddr", link_addr, 8'h18);

        // Stall with branch held
        stall = 1; br_valid = 1; br_taken = 1; br_target = 8'h20;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_q($sformatf("stl%0d", i), 8'h40, 8'h44, 2'd2, 1'b0);
        end
        stall = 0;
        step(); clr_br();
        chk_q("stl.exit", 8'h44, 8'h20, 2'd1, 1'b1);
        step(); chk_q("stl.tgt", 8'h20, 8'h24, 2'd1, 1'b1);
        stall = 1; flush = 1; flush_pc = 8'h80;
        step(); stall = 0; flush = 0;
        chk_q("stl.flush", 8'h80, 8'h84, 2'd1, 1'b1);

        // Wrap, sequential then branch to 0x00 at 0xFC
        do_flush(8'hF8);
        chk_q("wr0", 8'hF8, 8'hFC, 2'd1, 1'b1);
        step(); chk_q("wr1", 8'hFC, 8'h00, 2'd1, 1'b1);
        step(); chk_q("wr2", 8'h00, 8'h04, 2'd1, 1'b1);
        step(); chk_q("wr3", 8'h04, 8'h08, 2'd1, 1'b1);
        do_flush(8'hF8);
        step(); chk_q("wb0", 8'hFC, 8'h00, 2'd1, 1'b1);
        br_valid = 1; br_taken = 1; br_target = 8'h00; br_link = 1;
        step(); clr_br();
        chk_q("wb1", 8'h00, 8'h00, 2'd1, 1'b1);
        check("wb.lwe", link_we, 1'b1);
        check("wb.laddr", link_addr, 8'h04);
        step(); chk_q("wb2", 8'h00, 8'h04, 2'd1, 1'b1);

        // Not-taken branch: sequential, no link, no nullify
        br_valid = 1; br_taken = 0; br_target = 8'h90; br_link = 1; br_nullify = 1;
        step(); clr_br();
        chk_q("nt", 8'h04, 8'h08, 2'd1, 1'b1);
        check("nt.lwe", link_we, 1'b0);
        check("nt.sn", slot_nullify, 1'b0);

        // Async reset in NULL with link pending
        do_flush(8'h10);
        br_valid = 1; br_taken = 1; br_target = 8'h40; br_nullify = 1; br_link = 1;
        step(); clr_br();
        check("pre.state", state, 2'd3);
        check("pre.lwe", link_we, 1'b1);
        #2 reset = 1;
        #1;
        chk_q("arst", 8'h00, 8'h04, 2'd0, 1'b0);
        check("arst.sn", slot_nullify, 1'b0);
        check("arst.lwe", link_we, 1'b0);
        check("arst.laddr", link_addr, 8'h00);
        step();
        reset = 0;
        chk_q("arel", 8'h00, 8'h04, 2'd0, 1'b0);
        step();
        chk_q("arel.run", 8'h00, 8'h04, 2'd1, 1'b1);
        check("arel.lwe", link_we, 1'b0);
        check("arel.sn", slot_nullify, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
